// File: rtl/btn_tick_ctrl.sv
// btn_tick_ctrl: turns the 100 Hz clock level into a one-cycle tick and uses it
// to debounce push-buttons with per-button press and auto-repeat pulses.
module btn_tick_ctrl #(
    parameter int N_BTN = 5,
    parameter int DEB_TICKS = 3,
    parameter int HOLD_TICKS = 30,
    parameter int RPT_TICKS = 8,
    parameter logic [N_BTN-1:0] RPT_EN = 5'b00111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_100hz,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             tick_out,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic             c1_q, c2_q, ch_q, tick_q, tick_d;
    logic [N_BTN-1:0] b1_q, b2_q, db_q, db_d, pulse_q, pulse_d;
    logic [5:0]       dcnt_q [N_BTN];
    logic [5:0]       dcnt_d [N_BTN];
    logic [5:0]       rcnt_q [N_BTN];
    logic [5:0]       rcnt_d [N_BTN];
    logic [1:0]       st_q [N_BTN];
    logic [1:0]       st_d [N_BTN];

    always_comb begin
        tick_d = c2_q & ~ch_q;
        for (int i = 0; i < N_BTN; i++) begin
            db_d[i] = db_q[i];
            dcnt_d[i] = dcnt_q[i];
            rcnt_d[i] = rcnt_q[i];
            st_d[i] = st_q[i];
            pulse_d[i] = 1'b0;
            if (tick_q) begin
                if (b2_q[i] == db_q[i])
                    dcnt_d[i] = '0;
                else if (dcnt_q[i] == 6'(DEB_TICKS - 1)) begin
                    db_d[i] = b2_q[i];
                    dcnt_d[i] = '0;
                end else
                    dcnt_d[i] = dcnt_q[i] + 6'd1;
                // A release seen on this tick wins over any repeat due now.
                if (st_q[i] == IDLE) begin
                    if (db_d[i] && !db_q[i]) begin
                        st_d[i] = HELD;
                        rcnt_d[i] = '0;
                        pulse_d[i] = 1'b1;
                    end
                end else if (!db_d[i]) begin
                    st_d[i] = IDLE;
                    rcnt_d[i] = '0;
                end else if (st_q[i] == HELD) begin
                    if (RPT_EN[i]) begin
                        if (rcnt_q[i] + 6'd1 == 6'(HOLD_TICKS)) begin
                            st_d[i] = REPEAT;
                            rcnt_d[i] = '0;
                            pulse_d[i] = 1'b1;
                        end else
                            rcnt_d[i] = rcnt_q[i] + 6'd1;
                    end
                end else if (rcnt_q[i] + 6'd1 == 6'(RPT_TICKS)) begin
                    rcnt_d[i] = '0;
                    pulse_d[i] = 1'b1;
                end else
                    rcnt_d[i] = rcnt_q[i] + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q <= 1'b0;
            c2_q <= 1'b0;
            ch_q <= 1'b0;
            tick_q <= 1'b0;
            b1_q <= '0;
            b2_q <= '0;
            db_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= '0;
                rcnt_q[i] <= '0;
                st_q[i] <= IDLE;
            end
        end else begin
            c1_q <= clk_100hz;
            c2_q <= c1_q;
            ch_q <= c2_q;
            tick_q <= tick_d;
            b1_q <= btn_raw;
            b2_q <= b1_q;
            db_q <= db_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                rcnt_q[i] <= rcnt_d[i];
                st_q[i] <= st_d[i];
            end
        end
    end

    assign tick_out = tick_q;
    assign btn_level = db_q;
    assign btn_pulse = pulse_q;
endmodule
